time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/clock_pkg.sv | 68 ++++++
 rtl/tick_gen.sv | 47 ++++
 rtl/time_counter.sv | 106 ++++++++++
 tb/tb_time_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared definitions for the clock family (time counter, alarm,
//               set and display blocks): BCD digit limits, the packed HH:MM
//               time type, and helpers to validate and advance a BCD time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int         BCD_W               = 4;
    localparam logic [3:0] MAX_DIGIT           = 4'd9;
    localparam logic [3:0] MAX_HOUR_TENS       = 4'd2;
    localparam logic [3:0] MAX_HOUR_UNITS_AT_2 = 4'd3;
    localparam logic [3:0] MAX_MIN_TENS        = 4'd5;
    localparam logic [5:0] SECS_PER_MIN        = 6'd60;

    // HH:MM in BCD, most significant digit first (matches the 16-bit bus).
    typedef struct packed {
        logic [BCD_W-1:0] hour_tens;
        logic [BCD_W-1:0] hour_units;
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_units;
    } hhmm_t;

    // True when every digit is decimal and the time lies in 00:00..23:59.
    function automatic logic time_valid(input hhmm_t t);
        logic ok;
        ok = (t.hour_tens  <= MAX_HOUR_TENS) &&
             (t.hour_units <= MAX_DIGIT)     &&
             (t.min_tens   <= MAX_MIN_TENS)  &&
             (t.min_units  <= MAX_DIGIT);
        if (t.hour_tens == MAX_HOUR_TENS && t.hour_units > MAX_HOUR_UNITS_AT_2) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Advance a valid BCD time by one minute, wrapping 23:59 -> 00:00.
    function automatic hhmm_t time_inc(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.min_units != MAX_DIGIT) begin
            r.min_units = t.min_units + 4'd1;
        end else begin
            r.min_units = 4'd0;
            if (t.min_tens != MAX_MIN_TENS) begin
                r.min_tens = t.min_tens + 4'd1;
            end else begin
                r.min_tens = 4'd0;
                if (t.hour_tens == MAX_HOUR_TENS && t.hour_units == MAX_HOUR_UNITS_AT_2) begin
                    r.hour_tens  = 4'd0;
                    r.hour_units = 4'd0;
                end else if (t.hour_units == MAX_DIGIT) begin
                    r.hour_units = 4'd0;
                    r.hour_tens  = t.hour_tens + 4'd1;
                end else begin
                    r.hour_units = t.hour_units + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Prescaler. Counts 0..CLK_DIV-1 while en is high and asserts
//               tick (combinationally) during the cycle the count sits at
//               CLK_DIV-1; the count wraps to 0 on that same edge. clr has
//               priority over en and returns the count to 0.
// Ports       : clk     - rising-edge clock
//               reset_n - asynchronous active-low reset
//               en      - count enable
//               clr     - synchronous clear
//               tick    - one-cycle tick, high only while en is high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int CLK_DIV = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == c_last);
    assign tick      = en && w_at_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_counter.sv
// ============================================================================
// Module      : time_counter
// Description : BCD HH:MM time-of-day counter. A prescaler (tick_gen) turns
//               CLK_DIV clocks into one second tick; sixty seconds advance the
//               time by one minute. Loads of set_data are validated; a valid
//               load always wins over a coincident minute advance, an invalid
//               one is ignored and flagged on load_err one cycle later.
// Ports       : clk         - rising-edge clock
//               reset_n     - asynchronous active-low reset
//               run         - 1 = timekeeping advances, 0 = frozen
//               load_time   - load request for set_data
//               set_data    - BCD HH:MM to load
//               time_data   - registered BCD HH:MM time
//               minute_tick - one-cycle pulse after each minute advance
//               load_err    - one-cycle pulse after a rejected load
// Config      : TIME_COUNTER_FAST_EN - when defined, every second tick
//               advances one minute directly (no seconds counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        load_time,
    input  logic [15:0] set_data,
    output logic [15:0] time_data,
    output logic        minute_tick,
    output logic        load_err
);

    hhmm_t r_time;
    logic  r_minute_tick;
    logic  r_load_err;

    logic  w_set_valid;
    logic  w_load_ok;
    logic  w_load_bad;
    logic  w_sec_tick;
    logic  w_advance;

    assign w_set_valid = time_valid(hhmm_t'(set_data));
    assign w_load_ok   = load_time && w_set_valid;
    assign w_load_bad  = load_time && !w_set_valid;

    // A valid load restarts the second from its beginning.
    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .clr     (w_load_ok),
        .tick    (w_sec_tick)
    );

`ifdef TIME_COUNTER_FAST_EN
    assign w_advance = w_sec_tick;
`else
    logic [5:0] r_seconds;
    logic       w_sec_wrap;

    assign w_sec_wrap = (r_seconds == SECS_PER_MIN - 6'd1);
    assign w_advance  = w_sec_tick && w_sec_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seconds <= 6'd0;
        end else if (w_load_ok) begin
            r_seconds <= 6'd0;
        end else if (w_sec_tick) begin
            r_seconds <= w_sec_wrap ? 6'd0 : r_seconds + 6'd1;
        end
    end
`endif

    // Load has priority: a coincident minute advance is dropped entirely,
    // including its minute_tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_time        <= '0;
            r_minute_tick <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_minute_tick <= w_advance && !w_load_ok;
            r_load_err    <= w_load_bad;
            if (w_load_ok) begin
                r_time <= hhmm_t'(set_data);
            end else if (w_advance) begin
                r_time <= time_inc(r_time);
            end
        end
    end

    assign time_data   = r_time;
    assign minute_tick = r_minute_tick;
    assign load_err    = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_time_counter.sv
// ============================================================================
// Module      : tb_time_counter
// Description : Self-checking bench for time_counter (CLK_DIV = 4). A model
//               keeps time as minutes-of-day plus seconds and prescaler phase
//               as plain integers and converts to BCD only for comparison.
//               Directed steps cover reset, carries, day wrap, rejected loads,
//               load/advance collision and async reset, followed by random
//               run/load traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_counter;

    localparam int CLK_DIV = 4;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        run       = 1'b0;
    logic        load_time = 1'b0;
    logic [15:0] set_data  = 16'h0000;
    logic [15:0] time_data;
    logic        minute_tick;
    logic        load_err;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_pre  = 0;
    int m_sec  = 0;
    int m_mod  = 0;
    bit m_tick = 0;
    bit m_err  = 0;

    time_counter #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .load_time   (load_time),
        .set_data    (set_data),
        .time_data   (time_data),
        .minute_tick (minute_tick),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    function automatic bit valid_time(input logic [15:0] d);
        int ht, hu, mt, mu;
        ht = int'(d[15:12]);
        hu = int'(d[11:8]);
        mt = int'(d[7:4]);
        mu = int'(d[3:0]);
        return (ht <= 9) && (hu <= 9) && (mt <= 9) && (mu <= 9) &&
               (ht * 10 + hu <= 23) && (mt * 10 + mu <= 59);
    endfunction

    function automatic int minutes_of(input logic [15:0] d);
        return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 +
               int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int mod);
        int hh, mm;
        hh = mod / 60;
        mm = mod % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    task automatic model_reset();
        m_pre  = 0;
        m_sec  = 0;
        m_mod  = 0;
        m_tick = 0;
        m_err  = 0;
    endtask

    task automatic model_advance();
        m_mod  = (m_mod + 1) % 1440;
        m_tick = 1;
    endtask

    // One rising edge of behaviour, using the inputs present at that edge.
    task automatic model_edge();
        bit v;
        bit sec_tick;
        v      = valid_time(set_data);
        m_tick = 0;
        m_err  = load_time && !v;
        if (load_time && v) begin
            m_mod = minutes_of(set_data);
            m_sec = 0;
            m_pre = 0;
        end else if (run) begin
            sec_tick = (m_pre == CLK_DIV - 1);
            m_pre    = (m_pre + 1) % CLK_DIV;
            if (sec_tick) begin
`ifdef TIME_COUNTER_FAST_EN
                model_advance();
`else
                m_sec = m_sec + 1;
                if (m_sec == 60) begin
                    m_sec = 0;
                    model_advance();
                end
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("time_data",   time_data,        to_bcd(m_mod));
        chk("minute_tick", 16'(minute_tick), 16'(m_tick));
        chk("load_err",    16'(load_err),    16'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d);
        load_time = 1'b1;
        set_data  = d;
        step();
        load_time = 1'b0;
    endtask

    initial begin
        // reset acts without a clock edge
        reset_n = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;

`ifdef TIME_COUNTER_FAST_EN
        steps(3 * CLK_DIV);
        chk("fast_three_ticks", time_data, 16'h0003);
`else
        // first minute: tick registered on edge 240, visible right after it
        steps(239);
        chk("pre_first_minute", 16'(minute_tick), 16'h0000);
        step();
        chk("first_minute_time", time_data, 16'h0001);
        chk("first_minute_tick", 16'(minute_tick), 16'h0001);
        step();
        chk("tick_one_cycle", 16'(minute_tick), 16'h0000);

        // carries, day wrap and the 09->10 / 19->20 hour transitions
        do_load(16'h1259); steps(240); chk("carry_1300", time_data, 16'h1300);
        do_load(16'h2359); steps(240); chk("day_wrap",   time_data, 16'h0000);
        do_load(16'h0959); steps(240); chk("hour_1000",  time_data, 16'h1000);
        do_load(16'h1959); steps(240); chk("hour_2000",  time_data, 16'h2000);

        // rejected loads leave time alone and pulse load_err once
        run = 1'b0;
        do_load(16'h1234);
        do_load(16'h2400);
        chk("rej_2400_time", time_data, 16'h1234);
        chk("rej_2400_err",  16'(load_err), 16'h0001);
        step();
        chk("rej_err_clear", 16'(load_err), 16'h0000);
        do_load(16'h1260);
        chk("rej_1260_time", time_data, 16'h1234);
        do_load(16'h0A00);
        chk("rej_0A00_time", time_data, 16'h1234);
        step();

        // load landing on the exact minute-advance edge wins
        do_load(16'h1259);
        run = 1'b1;
        steps(239);
        do_load(16'h0805);
        chk("collide_time", time_data, 16'h0805);
        chk("collide_tick", 16'(minute_tick), 16'h0000);
        steps(239);
        chk("collide_sec0_hold", time_data, 16'h0805);
        step();
        chk("collide_sec0_adv", time_data, 16'h0806);

        // held load keeps seconds and prescaler at zero
        load_time = 1'b1;
        set_data  = 16'h1111;
        steps(10);
        load_time = 1'b0;
        steps(239);
        chk("held_load_hold", time_data, 16'h1111);
        step();
        chk("held_load_adv", time_data, 16'h1112);
`endif

        // async reset mid-second with run low
        run = 1'b1;
        do_load(16'h1530);
        steps(2);
        run = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_reset_time", time_data, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            load_time = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 1)
                set_data = to_bcd(int'($urandom_range(0, 1439)));
            else
                set_data = 16'($urandom);
            step();
        end
        load_time = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
